// File: rtl/fifo_rr_arbiter_if.sv
// Producer-side and FIFO-side handshake bundle for fifo_rr_arbiter.
// slave = arbiter view, master = the environment driving producers and the FIFO ready.
interface fifo_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int LB_NUM_REQ = $clog2(NUM_REQ)
);
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]            in_valid;
  logic [NUM_REQ-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [LB_NUM_REQ-1:0]         out_id;
  logic                          out_valid;
  logic                          out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_id, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_id, out_valid
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ valid/ready streams into one registered FIFO input.
// Optional per-requester saturating beat counters when ARB_STATS_EN is defined.
module fifo_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int LB_NUM_REQ = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  fifo_rr_arbiter_if.slave       bus
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  beat_cnt
`endif
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state_reg, state_next;
  logic [LB_NUM_REQ-1:0]   ptr_reg, ptr_next;
  logic [LB_NUM_REQ-1:0]   grant_reg, grant_next;
  logic [CW-1:0]           burst_cnt_reg, burst_cnt_next;
  logic [DATA_WIDTH-1:0]   out_data_reg;
  logic [LB_NUM_REQ-1:0]   out_id_reg;
  logic                    out_valid_reg;

  logic [LB_NUM_REQ-1:0]   sel;
  logic                    sel_found;
  logic                    can_load;
  logic                    accept;
  logic [NUM_REQ-1:0]      ready;
  logic [LB_NUM_REQ-1:0]   acc_id;
  logic [DATA_WIDTH-1:0]   beats [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign beats[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [LB_NUM_REQ-1:0] wrap_inc(input logic [LB_NUM_REQ-1:0] i);
    return (i == LB_NUM_REQ'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign can_load = !out_valid_reg || bus.out_ready;

  // Descending scan so the requester closest to ptr (smallest offset) wins.
  always_comb begin
    int idx;
    idx       = 0;
    sel       = '0;
    sel_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_reg) + k) % NUM_REQ;
      if (bus.in_valid[idx]) begin
        sel       = LB_NUM_REQ'(idx);
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      grant_reg     <= '0;
      burst_cnt_reg <= '0;
    end else if (clear) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      grant_reg     <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      grant_reg     <= grant_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    grant_next     = grant_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found && can_load) begin
          grant_next     = sel;
          burst_cnt_next = CW'(1);
          if (MAX_BURST == 1) ptr_next = wrap_inc(sel);
          else                state_next = BURST;
        end
      end
      BURST: begin
        // A holder that drops valid forfeits the rest of its burst.
        if (!bus.in_valid[grant_reg]) begin
          state_next = IDLE;
          ptr_next   = wrap_inc(grant_reg);
        end else if (can_load) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
          if (int'(burst_cnt_reg) + 1 == MAX_BURST) begin
            state_next = IDLE;
            ptr_next   = wrap_inc(grant_reg);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready  = '0;
    acc_id = (state_reg == BURST) ? grant_reg : sel;
    if (!clear) begin
      if (state_reg == BURST) ready[grant_reg] = can_load;
      else if (sel_found)     ready[sel]       = can_load;
    end
    accept = |(ready & bus.in_valid);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
    end else if (clear) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= beats[acc_id];
      out_id_reg    <= acc_id;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = out_data_reg;
  assign bus.out_id    = out_id_reg;
  assign bus.out_valid = out_valid_reg;

`ifdef ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [15:0] cnt_reg;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                   cnt_reg <= '0;
      else if (clear)                              cnt_reg <= '0;
      else if (accept && acc_id == LB_NUM_REQ'(gi) && cnt_reg != 16'hFFFF)
                                                   cnt_reg <= cnt_reg + 16'd1;
    end
    assign beat_cnt[gi*16 +: 16] = cnt_reg;
  end
`endif
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Randomized and directed bench for fifo_rr_arbiter against a transaction-level round-robin model.
module tb_fifo_rr_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int LB = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  fifo_rr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus();
`ifdef ARB_STATS_EN
  logic [N*16-1:0] beat_cnt;
`endif

  fifo_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (clear),
    .bus      (bus)
`ifdef ARB_STATS_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: who currently holds the grant (-1 none), beats taken, rotation pointer, output register.
  bit          m_valid;
  logic [7:0]  m_data;
  int          m_id;
  int          holder;
  int          taken;
  int          ptr;
  int          m_cnt [N];
  logic [N-1:0] exp_ready, got_ready;

  task automatic model_reset();
    m_valid = 0; m_data = 8'h00; m_id = 0; holder = -1; taken = 0; ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic ordy, input logic clr);
    bit can;
    int g;
    logic [N-1:0] acc;
    @(negedge clk);
    bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy; clear = clr;
    #1;
    got_ready = bus.in_ready;
    can = !m_valid || ordy;
    exp_ready = '0;
    g = -1;
    if (!clr) begin
      if (holder >= 0) g = holder;
      else begin
        for (int k = 0; k < N; k++) begin
          if (v[(ptr + k) % N]) begin g = (ptr + k) % N; break; end
        end
      end
      if (g >= 0 && can) exp_ready[g] = 1'b1;
    end
    acc = exp_ready & v;
    if (clr) model_reset();
    else begin
      if (acc != 0) begin
        if (holder < 0) taken = 0;
        taken++;
        m_valid = 1; m_data = d[g*DW +: DW]; m_id = g;
        if (m_cnt[g] < 65535) m_cnt[g]++;
        if (taken == MB) begin holder = -1; ptr = (g + 1) % N; end
        else holder = g;
      end else begin
        if (holder >= 0 && !v[holder]) begin ptr = (holder + 1) % N; holder = -1; end
        if (ordy) m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b1; clear = 1'b0;
    model_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_id !== 2'd0 || bus.in_ready !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_hold: valid=%b data=%h id=%0d ready=%b, required 0/00/0/0000",
               bus.out_valid, bus.out_data, bus.out_id, bus.in_ready);
    end
    @(negedge clk) rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000, '0, 1'b1, 1'b0);
      vectors++;
      if (got_ready !== 4'b0 || bus.out_valid !== 1'b0 || bus.out_id !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: ready=%b valid=%b id=%0d, required 0000/0/0", i, got_ready, bus.out_valid, bus.out_id);
      end
    end
  endtask

  task automatic test_single_stream();
    logic [N*DW-1:0] d;
    for (int i = 0; i < 6; i++) begin
      d = '0;
      d[7:0] = 8'h10 + 8'(i);
      cycle(4'b0001, d, 1'b1, 1'b0);
      vectors++;
      if (got_ready !== 4'b0001 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h10 + 8'(i) || bus.out_id !== 2'd0) begin
        miscompares++;
        $display("FAIL single_stream[%0d]: ready=%b valid=%b data=%h id=%0d, required 0001/1/%h/0",
                 i, got_ready, bus.out_valid, bus.out_data, bus.out_id, 8'h10 + 8'(i));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N*DW-1:0] d;
    cycle(4'b0000, '0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      d = {$urandom, $urandom};
      cycle(4'b1111, d, 1'b1, 1'b0);
      vectors++;
      if (!$onehot(got_ready) || bus.out_valid !== 1'b1 || bus.out_id !== 2'((i / 4) % 4) || bus.out_data !== d[((i/4)%4)*DW +: DW]) begin
        miscompares++;
        $display("FAIL round_robin[%0d]: ready=%b valid=%b id=%0d data=%h, required id=%0d data=%h",
                 i, got_ready, bus.out_valid, bus.out_id, bus.out_data, (i / 4) % 4, d[((i/4)%4)*DW +: DW]);
      end
    end
  endtask

  task automatic test_drop_valid();
    logic [N-1:0] vseq [5];
    logic [N-1:0] rseq [5];
    vseq = '{4'b1100, 4'b1100, 4'b1000, 4'b1100, 4'b1100};
    rseq = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    cycle(4'b0000, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(vseq[i], {$urandom}, 1'b1, 1'b0);
      vectors++;
      if (got_ready !== rseq[i] || got_ready !== exp_ready || bus.out_valid !== m_valid || (m_valid && bus.out_id !== LB'(m_id))) begin
        miscompares++;
        $display("FAIL drop_valid[%0d]: ready=%b valid=%b id=%0d, required ready=%b valid=%b id=%0d",
                 i, got_ready, bus.out_valid, bus.out_id, rseq[i], m_valid, m_id);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] held;
    cycle(4'b0000, '0, 1'b1, 1'b1);
    cycle(4'b0010, 32'h0000_5A00, 1'b1, 1'b0);
    held = bus.out_data;
    vectors++;
    if (held !== 8'h5A || bus.out_id !== 2'd1) begin
      miscompares++;
      $display("FAIL stall_load: data=%h id=%0d, required 5a/1", held, bus.out_id);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0010, {$urandom}, 1'b0, 1'b0);
      vectors++;
      if (got_ready !== 4'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A || bus.out_id !== 2'd1) begin
        miscompares++;
        $display("FAIL stall[%0d]: ready=%b valid=%b data=%h id=%0d, required 0000/1/5a/1",
                 i, got_ready, bus.out_valid, bus.out_data, bus.out_id);
      end
    end
    cycle(4'b0010, 32'h0000_A500, 1'b1, 1'b0);
    vectors++;
    if (got_ready !== 4'b0010 || bus.out_data !== 8'hA5 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_resume: ready=%b data=%h valid=%b, required 0010/a5/1", got_ready, bus.out_data, bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    cycle(4'b0001, 32'h0000_0077, 1'b1, 1'b0);
    cycle(4'b0001, 32'h0000_0078, 1'b1, 1'b0);
    @(negedge clk);
    bus.in_valid = '0;
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_id !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b data=%h id=%0d, required 0/00/0", bus.out_valid, bus.out_data, bus.out_id);
    end
    model_reset();
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic ordy, clr;
    for (int i = 0; i < 400; i++) begin
      v = 4'($urandom);
      ordy = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 49) == 0);
      cycle(v, {$urandom}, ordy, clr);
      vectors++;
      if (got_ready !== exp_ready || !$onehot0(got_ready) || bus.out_valid !== m_valid ||
          (m_valid && (bus.out_data !== m_data || bus.out_id !== LB'(m_id)))) begin
        miscompares++;
        $display("FAIL random[%0d]: ready=%b valid=%b data=%h id=%0d, required ready=%b valid=%b data=%h id=%0d",
                 i, got_ready, bus.out_valid, bus.out_data, bus.out_id, exp_ready, m_valid, m_data, m_id);
      end
`ifdef ARB_STATS_EN
      for (int r = 0; r < N; r++) begin
        vectors++;
        if (beat_cnt[r*16 +: 16] !== 16'(m_cnt[r])) begin
          miscompares++;
          $display("FAIL stats_random[%0d] req%0d: count=%0d, required %0d", i, r, beat_cnt[r*16 +: 16], m_cnt[r]);
        end
      end
`endif
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    cycle(4'b0000, '0, 1'b1, 1'b1);
    vectors++;
    if (beat_cnt !== '0) begin
      miscompares++;
      $display("FAIL stats_clear: beat_cnt=%h, required 0", beat_cnt);
    end
    for (int i = 0; i < 70000; i++) cycle(4'b0001, {$urandom}, 1'b1, 1'b0);
    vectors++;
    if (beat_cnt[15:0] !== 16'hFFFF || beat_cnt[63:16] !== '0) begin
      miscompares++;
      $display("FAIL stats_saturate: beat_cnt=%h, required 0000_0000_0000_ffff", beat_cnt);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_drop_valid();
    test_stall();
    test_async_reset();
    test_random();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
